// File: rtl/fifo_ctrl_16x8.sv
// FIFO controller for the 16x8 dual-port RAM: one-cycle read latency (pop_valid follows accepted pop).
// Full FIFO rejects a lone push (overflow), empty FIFO rejects pop (underflow); push on full accepted only with a pop.
module fifo_ctrl_16x8 #(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 8,
  parameter int AF_LEVEL = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     clr_err,
  output logic                     ram_wr,
  output logic                     ram_rd,
  output logic [$clog2(DEPTH)-1:0] ram_w_add,
  output logic [$clog2(DEPTH)-1:0] ram_r_add,
  output logic [WIDTH-1:0]         ram_din,
  input  logic [WIDTH-1:0]         ram_dout,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     pop_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LEVEL);

  // Extra wrap bit distinguishes full from empty when the addresses coincide.
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        push_acc;
  logic        pop_acc;

  assign count       = wptr - rptr;
  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign almost_full = (count >= AF_CNT);

  assign pop_acc  = pop & ~empty;
  assign push_acc = push & (~full | pop_acc);

  assign ram_wr    = push_acc;
  assign ram_rd    = pop_acc;
  assign ram_w_add = wptr[AW-1:0];
  assign ram_r_add = rptr[AW-1:0];
  assign ram_din   = push_data;
  assign pop_data  = ram_dout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_acc) wptr <= wptr + 1'b1;
      if (pop_acc)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop_valid <= 1'b0;
    end else begin
      pop_valid <= pop_acc;
    end
  end

  // A rejection in the same cycle as clr_err keeps its flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  & ~clr_err) | (push & ~push_acc);
      underflow <= (underflow & ~clr_err) | (pop  & ~pop_acc);
    end
  end

endmodule

// File: tb/tb_fifo_ctrl_16x8.sv
module tb_fifo_ctrl_16x8;

  logic       clk = 1'b0;
  logic       reset;
  logic       push;
  logic [7:0] push_data;
  logic       pop;
  logic       clr_err;
  logic       ram_wr;
  logic       ram_rd;
  logic [3:0] ram_w_add;
  logic [3:0] ram_r_add;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic [7:0] pop_data;
  logic       pop_valid;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       overflow;
  logic       underflow;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fifo_ctrl_16x8 #(.DEPTH(16), .WIDTH(8), .AF_LEVEL(12)) dut (
    .clk(clk), .reset(reset), .push(push), .push_data(push_data), .pop(pop),
    .clr_err(clr_err), .ram_wr(ram_wr), .ram_rd(ram_rd), .ram_w_add(ram_w_add),
    .ram_r_add(ram_r_add), .ram_din(ram_din), .ram_dout(ram_dout),
    .pop_data(pop_data), .pop_valid(pop_valid), .count(count), .full(full),
    .empty(empty), .almost_full(almost_full), .overflow(overflow),
    .underflow(underflow)
  );

  // Dual-port RAM: registered read, read-before-write on address collision.
  logic [7:0] mem [16];
  always_ff @(posedge clk) begin
    if (ram_rd) ram_dout <= mem[ram_r_add];
    if (ram_wr) mem[ram_w_add] <= ram_din;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic p, input logic [7:0] d, input logic q, input logic c);
    push = p; push_data = d; pop = q; clr_err = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; push_data = 8'h00; pop = 1'b0; clr_err = 1'b0;
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_pop_valid", 32'(pop_valid), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_udf", 32'(underflow), 0);
    chk("rst_ram_wr", 32'(ram_wr), 0);
    chk("rst_ram_rd", 32'(ram_rd), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Fill with 0x14..0x23
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(8'h14 + i), 1'b0, 1'b0);
      chk("fill_ram_wr", 32'(ram_wr), 1);
      chk("fill_w_add", 32'(ram_w_add), 32'(i));
      tick();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_af", 32'(almost_full), 32'(i + 1 >= 12));
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_ovf", 32'(overflow), 0);

    // Lone push while full
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    chk("ovf_ram_wr", 32'(ram_wr), 0);
    tick();
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 16);

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_ram_rd", 32'(ram_rd), 1);
      tick();
      chk("drain_valid", 32'(pop_valid), 1);
      chk("drain_data", 32'(pop_data), 32'(8'h14 + i));
    end
    chk("drain_empty", 32'(empty), 1);
    tick();
    chk("idle_valid", 32'(pop_valid), 0);

    // Pop while empty, then clear flags
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("udf_ram_rd", 32'(ram_rd), 0);
    tick();
    chk("udf_flag", 32'(underflow), 1);
    chk("udf_valid", 32'(pop_valid), 0);
    chk("udf_ovf_sticky", 32'(overflow), 1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_udf", 32'(underflow), 0);

    // Fill with 0x60..0x6F, then 20 simultaneous push/pop cycles
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      tick();
    end
    chk("refill_full", 32'(full), 1);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
      chk("pp_ram_wr", 32'(ram_wr), 1);
      chk("pp_ram_rd", 32'(ram_rd), 1);
      chk("pp_w_add", 32'(ram_w_add), 32'(i % 16));
      chk("pp_r_add", 32'(ram_r_add), 32'(i % 16));
      tick();
      chk("pp_count", 32'(count), 16);
      chk("pp_valid", 32'(pop_valid), 1);
      chk("pp_data", 32'(pop_data), (i < 16) ? 32'(8'h60 + i) : 32'(8'h80 + i - 16));
    end
    chk("pp_ovf", 32'(overflow), 0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      chk("pp_drain_data", 32'(pop_data), 32'(8'h84 + i));
    end
    chk("pp_drain_empty", 32'(empty), 1);

    // Push and pop together on empty: no fall-through
    drive(1'b1, 8'hA5, 1'b1, 1'b0);
    chk("ef_ram_wr", 32'(ram_wr), 1);
    chk("ef_ram_rd", 32'(ram_rd), 0);
    tick();
    chk("ef_count", 32'(count), 1);
    chk("ef_udf", 32'(underflow), 1);
    chk("ef_valid0", 32'(pop_valid), 0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    chk("ef_valid1", 32'(pop_valid), 1);
    chk("ef_data", 32'(pop_data), 32'h0000_00A5);
    chk("ef_empty", 32'(empty), 1);

    // Mid-cycle reset with data queued and pop_valid pending
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    chk("pre_rst_valid", 32'(pop_valid), 1);
    chk("pre_rst_count", 32'(count), 4);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_valid", 32'(pop_valid), 0);
    chk("mid_rst_udf", 32'(underflow), 0);
    #1 reset = 1'b0;
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    tick();
    chk("post_rst_count", 32'(count), 1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    chk("post_rst_valid", 32'(pop_valid), 1);
    chk("post_rst_data", 32'(pop_data), 32'h0000_003C);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
